regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and buffer that shares the register file's single write port between two producers: the ALU result path (requester 0) and the memory-load path (requester 1). Producers hand off writes over valid/ready; accepted writes queue in a 2-entry FIFO that drives the register file's write_en/dst_reg/dst_data. The block also exports a busy mask and a forwarding lookup, so decode can stall or bypass on registers with writes still queued.

## Interface
- DISCARD_R0, 1, when 1 writes to register 0 are accepted but never queued or written
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 (ALU) has a write
- req0_reg  input  4  requester 0 destination register
- req0_data  input  16  requester 0 write data
- req0_ready  output  1  requester 0 handshake accepted this cycle
- req1_valid  input  1  requester 1 (load) has a write
- req1_reg  input  4  requester 1 destination register
- req1_data  input  16  requester 1 write data
- req1_ready  output  1  requester 1 handshake accepted this cycle
- wr_hold  input  1  register file must not be written this cycle
- write_en  output  1  write strobe to register file
- dst_reg  output  4  register file write address (FIFO head)
- dst_data  output  16  register file write data (FIFO head)
- busy_mask  output  16  bit i set while any queued entry targets register i
- lookup_reg  input  4  forwarding query register
- fwd_hit  output  1  lookup_reg has a queued write
- fwd_data  output  16  data of youngest queued write to lookup_reg, 0 when no hit

## Operation
- State: 2-entry FIFO (reg, data), 2-bit count, head pointer, 1-bit rr_last (last requester granted).
- Arbitration (combinational): space = (count < 2) and rst high. Only req0 valid → grant 0. Only req1 valid → grant 1. Both valid → grant the requester != rr_last. reqN_ready = space and grant == N. At most one ready per cycle.
- Ready is not asserted on the strength of a same-cycle pop: count == 2 → both ready 0, even if write_en is 1.
- Handshake = valid and ready. On handshake: rr_last <= granted index. Push {reg, data} unless DISCARD_R0 = 1 and reg == 0; a discarded handshake still updates rr_last and pushes nothing.
- Drain: write_en = (count != 0) and not wr_hold. dst_reg/dst_data = head entry whenever count != 0, else 0. The head pops on every cycle write_en is 1.
- Push and pop in the same cycle: count unchanged, and the FIFO order is preserved.
- busy_mask: OR of one-hot(reg) over the valid entries. Both entries may target the same register.
- Forwarding: fwd_hit = any valid entry with reg == lookup_reg. fwd_data = data of the youngest matching entry, else 0.
- Order: writes reach the register file strictly in acceptance order.

## Timing
- Reset (rst low, async): count 0, head 0, rr_last 1 (requester 0 wins the first tie). Outputs while in reset: write_en 0, dst_reg 0, dst_data 0, busy_mask 0, fwd_hit 0, fwd_data 0, req0_ready 0, req1_ready 0.
- Reset release: ready may assert in the first cycle with rst high.
- Reset mid-operation: queued writes are lost and write_en drops immediately.
- Latency: a handshake at edge N with the FIFO empty and wr_hold low → write_en high during cycle N+1, and the register file captures the write at edge N+1.
- Throughput: one write per cycle sustained. Each requester gets at least one grant in every 2 contested handshakes.
- wr_hold high: no pop. Pushes continue until count == 2, then both ready signals stay 0 until the hold releases.
- busy_mask and fwd_* update the cycle after a push. They clear for an entry in the cycle after its pop.

## Test plan
- Reset behaviour: hold rst low with both valid, then release. → While rst is low, all outputs are 0. At the first edge after release, req0 is granted (rr_last = 1).
- Contention: hold req0 and req1 valid with regs 3 and 5 for 4 cycles. → Grants alternate 0,1,0,1, and write_en shows R3, R5, R3, R5 in order, each one cycle after its handshake.
- Full/hold: assert wr_hold and push to R7 (data 0x1111), then R7 (data 0x2222). → count reaches 2 and both ready signals go 0. busy_mask = 0x0080; lookup_reg = 7 gives fwd_hit 1, fwd_data 0x2222. After wr_hold drops, the writes 0x1111 then 0x2222 follow on consecutive cycles, and busy_mask returns to 0.
- Simultaneous push/pop: with count = 1, push R2 while the head pops. → count stays 1, and R2 is written the next cycle.
- R0 discard (DISCARD_R0 = 1): req1 writes R0 with data 0xBEEF. → req1_ready 1, rr_last becomes 1, no write_en, busy_mask unchanged.
- Async reset mid-operation: pulse rst low for half a cycle with 2 entries queued. → write_en, count and busy_mask clear immediately, and no queued write reaches the register file.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: round-robin between the ALU and load producers, feeding a 2-entry
// FIFO that drives the register file write port, with busy-mask and forwarding lookup.
module regfile_wb_arbiter #(
   parameter bit DISCARD_R0 = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [3:0]  req0_reg,
   input  logic [15:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [3:0]  req1_reg,
   input  logic [15:0] req1_data,
   output logic        req1_ready,
   input  logic        wr_hold,
   output logic        write_en,
   output logic [3:0]  dst_reg,
   output logic [15:0] dst_data,
   output logic [15:0] busy_mask,
   input  logic [3:0]  lookup_reg,
   output logic        fwd_hit,
   output logic [15:0] fwd_data
);
   logic [1:0]  count_q, count_d;
   logic        head_q, head_d;
   logic        rr_last_q, rr_last_d;
   logic [3:0]  ent_reg_q  [2];
   logic [15:0] ent_data_q [2];
   logic [1:0]  ent_valid;

   logic        space, grant, hs, push, pop, tail;
   logic [3:0]  push_reg;
   logic [15:0] push_data;

   always_comb begin
      space = (count_q < 2'd2) && rst;
      // On a tie the requester that did not win last time goes next.
      if (req0_valid && req1_valid) grant = ~rr_last_q;
      else                          grant = req1_valid;
      req0_ready = space && req0_valid && !grant;
      req1_ready = space && req1_valid && grant;
      hs         = req0_ready || req1_ready;
      push_reg   = grant ? req1_reg  : req0_reg;
      push_data  = grant ? req1_data : req0_data;
      push       = hs && !(DISCARD_R0 && (push_reg == 4'd0));
      write_en   = (count_q != 2'd0) && !wr_hold;
      pop        = write_en;
      tail       = head_q ^ count_q[0];
      dst_reg    = (count_q != 2'd0) ? ent_reg_q[head_q]  : 4'd0;
      dst_data   = (count_q != 2'd0) ? ent_data_q[head_q] : 16'd0;
   end

   always_comb begin
      count_d   = count_q + {1'b0, push} - {1'b0, pop};
      head_d    = pop ? ~head_q : head_q;
      rr_last_d = hs ? grant : rr_last_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q   <= 2'd0;
         head_q    <= 1'b0;
         rr_last_q <= 1'b1;
      end else begin
         count_q   <= count_d;
         head_q    <= head_d;
         rr_last_q <= rr_last_d;
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_entry
         assign ent_valid[gi] = (count_q == 2'd2) || ((count_q == 2'd1) && (head_q == 1'(gi)));
         always_ff @(posedge clk) begin
            if (push && (tail == 1'(gi))) begin
               ent_reg_q[gi]  <= push_reg;
               ent_data_q[gi] <= push_data;
            end
         end
      end
   endgenerate

   // Head is checked first so the younger entry, when it also matches, overrides it.
   always_comb begin
      busy_mask = 16'd0;
      fwd_hit   = 1'b0;
      fwd_data  = 16'd0;
      for (int i = 0; i < 2; i++) begin
         if (ent_valid[i]) busy_mask[ent_reg_q[i]] = 1'b1;
      end
      if (ent_valid[head_q] && (ent_reg_q[head_q] == lookup_reg)) begin
         fwd_hit  = 1'b1;
         fwd_data = ent_data_q[head_q];
      end
      if ((count_q == 2'd2) && (ent_reg_q[~head_q] == lookup_reg)) begin
         fwd_hit  = 1'b1;
         fwd_data = ent_data_q[~head_q];
      end
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, contention, full/hold, push+pop, R0 discard
// and asynchronous reset while entries are queued.
module tb_regfile_wb_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [3:0]  req0_reg, req1_reg, dst_reg, lookup_reg;
   logic [15:0] req0_data, req1_data, dst_data, busy_mask, fwd_data;
   logic        wr_hold, write_en, fwd_hit;

   int n_checks = 0;
   int n_pass   = 0;

   regfile_wb_arbiter #(.DISCARD_R0(1'b1)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
      .wr_hold(wr_hold), .write_en(write_en), .dst_reg(dst_reg), .dst_data(dst_data),
      .busy_mask(busy_mask), .lookup_reg(lookup_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst && write_en) $display("write R%0d <= %04h", dst_reg, dst_data);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      req0_valid = 1'b1; req0_reg = 4'd3; req0_data = 16'hA003;
      req1_valid = 1'b1; req1_reg = 4'd5; req1_data = 16'hB005;
      lookup_reg = 4'd3;
      #12;
      n_checks++; if (write_en !== 1'b0) $display("FAIL rst_write_en: got %b want 0", write_en); else n_pass++;
      n_checks++; if (dst_reg !== 4'd0) $display("FAIL rst_dst_reg: got %0d want 0", dst_reg); else n_pass++;
      n_checks++; if (dst_data !== 16'd0) $display("FAIL rst_dst_data: got %h want 0", dst_data); else n_pass++;
      n_checks++; if (busy_mask !== 16'd0) $display("FAIL rst_busy: got %h want 0", busy_mask); else n_pass++;
      n_checks++; if ({fwd_hit, fwd_data} !== 17'd0) $display("FAIL rst_fwd: got %b/%h want 0/0", fwd_hit, fwd_data); else n_pass++;
      n_checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL rst_ready: got %b%b want 00", req0_ready, req1_ready); else n_pass++;
      rst = 1'b1;
      #1;
   endtask

   task automatic test_contention();
      logic       exp0;
      logic [3:0] exp_reg;
      for (int k = 0; k < 4; k++) begin
         exp0    = (k % 2 == 0);
         exp_reg = (k % 2 == 1) ? 4'd3 : 4'd5;
         n_checks++; if ({req0_ready, req1_ready} !== {exp0, ~exp0}) $display("FAIL cont_grant%0d: got %b%b want %b%b", k, req0_ready, req1_ready, exp0, ~exp0); else n_pass++;
         n_checks++; if (write_en !== (k > 0)) $display("FAIL cont_we%0d: got %b want %b", k, write_en, (k > 0)); else n_pass++;
         if (k > 0) begin
            n_checks++; if (dst_reg !== exp_reg) $display("FAIL cont_dst%0d: got R%0d want R%0d", k, dst_reg, exp_reg); else n_pass++;
            n_checks++; if (busy_mask !== (16'd1 << exp_reg)) $display("FAIL cont_busy%0d: got %h want %h", k, busy_mask, 16'd1 << exp_reg); else n_pass++;
         end
         step();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      n_checks++; if ({write_en, dst_reg, dst_data} !== {1'b1, 4'd5, 16'hB005}) $display("FAIL cont_last: got %b R%0d %h want 1 R5 b005", write_en, dst_reg, dst_data); else n_pass++;
      step();
      n_checks++; if ({write_en, busy_mask} !== 17'd0) $display("FAIL cont_empty: got %b %h want 0 0000", write_en, busy_mask); else n_pass++;
   endtask

   task automatic test_full_hold();
      wr_hold = 1'b1;
      req0_valid = 1'b1; req0_reg = 4'd7; req0_data = 16'h1111;
      #1;
      n_checks++; if (req0_ready !== 1'b1) $display("FAIL hold_rdy1: got %b want 1", req0_ready); else n_pass++;
      step();
      req0_data = 16'h2222;
      #1;
      n_checks++; if ({req0_ready, write_en} !== 2'b10) $display("FAIL hold_rdy2: got rdy %b we %b want 1 0", req0_ready, write_en); else n_pass++;
      step();
      req0_reg = 4'd9; req1_valid = 1'b1; req1_reg = 4'd9; lookup_reg = 4'd7;
      #1;
      n_checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL full_ready: got %b%b want 00", req0_ready, req1_ready); else n_pass++;
      n_checks++; if (write_en !== 1'b0) $display("FAIL full_we: got %b want 0", write_en); else n_pass++;
      n_checks++; if (busy_mask !== 16'h0080) $display("FAIL full_busy: got %h want 0080", busy_mask); else n_pass++;
      n_checks++; if ({fwd_hit, fwd_data} !== {1'b1, 16'h2222}) $display("FAIL full_fwd: got %b %h want 1 2222", fwd_hit, fwd_data); else n_pass++;
      step();
      n_checks++; if ({req0_ready, req1_ready, write_en} !== 3'b000) $display("FAIL full_stay: got %b%b we %b want 00 0", req0_ready, req1_ready, write_en); else n_pass++;
      req0_valid = 1'b0; req1_valid = 1'b0; wr_hold = 1'b0;
      #1;
      n_checks++; if ({write_en, dst_reg, dst_data} !== {1'b1, 4'd7, 16'h1111}) $display("FAIL drain1: got %b R%0d %h want 1 R7 1111", write_en, dst_reg, dst_data); else n_pass++;
      step();
      n_checks++; if ({write_en, dst_reg, dst_data} !== {1'b1, 4'd7, 16'h2222}) $display("FAIL drain2: got %b R%0d %h want 1 R7 2222", write_en, dst_reg, dst_data); else n_pass++;
      n_checks++; if ({busy_mask, fwd_data} !== {16'h0080, 16'h2222}) $display("FAIL drain2_fwd: got %h %h want 0080 2222", busy_mask, fwd_data); else n_pass++;
      step();
      n_checks++; if ({write_en, busy_mask, fwd_hit, fwd_data} !== 34'd0) $display("FAIL drain_done: got %b %h %b %h want all 0", write_en, busy_mask, fwd_hit, fwd_data); else n_pass++;
   endtask

   task automatic test_push_pop();
      req0_valid = 1'b1; req0_reg = 4'd4; req0_data = 16'h4444;
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_reg = 4'd2; req1_data = 16'h2020;
      #1;
      n_checks++; if ({write_en, dst_reg, req1_ready} !== {1'b1, 4'd4, 1'b1}) $display("FAIL pp_both: got we %b R%0d rdy %b want 1 R4 1", write_en, dst_reg, req1_ready); else n_pass++;
      step();
      req1_valid = 1'b0;
      #1;
      n_checks++; if ({write_en, dst_reg, dst_data} !== {1'b1, 4'd2, 16'h2020}) $display("FAIL pp_next: got %b R%0d %h want 1 R2 2020", write_en, dst_reg, dst_data); else n_pass++;
      n_checks++; if (busy_mask !== 16'h0004) $display("FAIL pp_busy: got %h want 0004", busy_mask); else n_pass++;
      step();
      n_checks++; if ({write_en, busy_mask} !== 17'd0) $display("FAIL pp_empty: got %b %h want 0 0000", write_en, busy_mask); else n_pass++;
   endtask

   task automatic test_discard();
      req0_valid = 1'b1; req0_reg = 4'd1; req0_data = 16'h0101;
      step();
      req0_valid = 1'b0;
      step();
      req1_valid = 1'b1; req1_reg = 4'd0; req1_data = 16'hBEEF;
      #1;
      n_checks++; if (req1_ready !== 1'b1) $display("FAIL disc_ready: got %b want 1", req1_ready); else n_pass++;
      step();
      req1_valid = 1'b0;
      #1;
      n_checks++; if ({write_en, busy_mask} !== 17'd0) $display("FAIL disc_nowrite: got %b %h want 0 0000", write_en, busy_mask); else n_pass++;
      req0_valid = 1'b1; req0_reg = 4'd6; req0_data = 16'h0606;
      req1_valid = 1'b1; req1_reg = 4'd8; req1_data = 16'h0808;
      #1;
      n_checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL disc_rrlast: got %b%b want 10", req0_ready, req1_ready); else n_pass++;
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      n_checks++; if ({write_en, dst_reg} !== {1'b1, 4'd6}) $display("FAIL disc_tie_write: got %b R%0d want 1 R6", write_en, dst_reg); else n_pass++;
      step();
   endtask

   task automatic test_async_reset();
      wr_hold = 1'b1;
      req0_valid = 1'b1; req0_reg = 4'd10; req0_data = 16'hAAAA;
      step();
      req0_reg = 4'd11; req0_data = 16'hBBBB;
      step();
      req0_valid = 1'b0; wr_hold = 1'b0;
      #1;
      n_checks++; if ({write_en, dst_data, busy_mask} !== {1'b1, 16'hAAAA, 16'h0C00}) $display("FAIL ar_pre: got %b %h %h want 1 aaaa 0c00", write_en, dst_data, busy_mask); else n_pass++;
      rst = 1'b0;
      #1;
      n_checks++; if ({write_en, dst_reg, dst_data, busy_mask} !== 37'd0) $display("FAIL ar_clear: got %b R%0d %h %h want all 0", write_en, dst_reg, dst_data, busy_mask); else n_pass++;
      #3;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         n_checks++; if ({write_en, busy_mask} !== 17'd0) $display("FAIL ar_lost%0d: got %b %h want 0 0000", k, write_en, busy_mask); else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b0; wr_hold = 1'b0; lookup_reg = 4'd0;
      req0_valid = 1'b0; req0_reg = 4'd0; req0_data = 16'd0;
      req1_valid = 1'b0; req1_reg = 4'd0; req1_data = 16'd0;
      test_reset();
      test_contention();
      test_full_hold();
      test_push_pop();
      test_discard();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
